// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot/binary grant and hold timeout
//
// Shares one resource among N requesters. The grant is registered, held until the
// owner pulses release_i (or MAX_HOLD cycles elapse), then re-arbitrated in the same
// cycle so back-to-back grants have no idle bubble.
//
// Ports:
//   clk          in   1      clock, all logic on posedge
//   rst          in   1      synchronous reset, active-high
//   req          in   N      level-sensitive request vector
//   release_i    in   1      owner done pulse while grant_valid=1
//   grant_onehot out  N      registered one-hot grant, zero when idle
//   grant_idx    out  IDX_W  binary index of grant_onehot, zero when idle
//   grant_valid  out  1      high while a grant is held
//   timeout      out  1      one-cycle pulse after a forced (MAX_HOLD) release
module rr_onehot_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             release_i,
  output logic [N-1:0]     grant_onehot,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [N-1:0]     OH_ONE    = N'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] search_start;
  logic             hold_limit;
  logic             rel_eff;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Pointer after the current owner releases; wraps mod N so indices >= N never occur.
  assign ptr_next     = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
  // While busy, the search for the successor already uses the post-release pointer.
  assign search_start = (state_q == BUSY) ? ptr_next : ptr_q;
  assign hold_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign rel_eff      = (state_q == BUSY) && (release_i || hold_limit);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int j = 0; j < N; j++) begin
      int cand;
      cand = int'(search_start) + j;
      if (cand >= N) cand = cand - N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d     = BUSY;
          grant_idx_d = win_idx;
          grant_oh_d  = OH_ONE << win_idx;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (rel_eff) begin
          ptr_d      = ptr_next;
          hold_cnt_d = '0;
          // A release requested on the limit cycle counts as normal, not a timeout.
          timeout_d  = hold_limit && !release_i;
          if (win_found) begin
            grant_idx_d = win_idx;
            grant_oh_d  = OH_ONE << win_idx;
          end else begin
            state_d     = IDLE;
            grant_idx_d = '0;
            grant_oh_d  = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_onehot = grant_oh_q;
  assign grant_idx    = grant_idx_q;
  assign grant_valid  = (state_q == BUSY);
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - bench for rr_onehot_arbiter: reference model plus directed vectors
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;

  logic [3:0] oh0, oh1;
  logic [2:0] oh2;
  logic [1:0] idx0, idx1, idx2;
  logic       v0, v1, v2, t0, t1, t2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(4), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .release_i(rel),
    .grant_onehot(oh0), .grant_idx(idx0), .grant_valid(v0), .timeout(t0));

  rr_onehot_arbiter #(.N(4), .MAX_HOLD(8)) dut1 (
    .clk(clk), .rst(rst), .req(req), .release_i(rel),
    .grant_onehot(oh1), .grant_idx(idx1), .grant_valid(v1), .timeout(t1));

  rr_onehot_arbiter #(.N(3), .MAX_HOLD(3)) dut2 (
    .clk(clk), .rst(rst), .req(req[2:0]), .release_i(rel),
    .grant_onehot(oh2), .grant_idx(idx2), .grant_valid(v2), .timeout(t2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner is -1 when idle, age counts cycles the grant has been shown.
  int nreq[3] = '{4, 4, 3};
  int mh[3]   = '{0, 8, 3};
  int m_owner[3];
  int m_ptr[3];
  int m_age[3];
  bit m_to[3];
  bit m_live = 1'b0;

  function automatic int pick(input int k, input int start);
    for (int j = 0; j < nreq[k]; j++) begin
      int i;
      i = (start + j) % nreq[k];
      if (req[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        for (int k = 0; k < 3; k++) begin
          logic [31:0] a_oh, a_idx, a_v, a_t, e_oh, e_idx;
          case (k)
            0:       begin a_oh = 32'(oh0); a_idx = 32'(idx0); a_v = 32'(v0); a_t = 32'(t0); end
            1:       begin a_oh = 32'(oh1); a_idx = 32'(idx1); a_v = 32'(v1); a_t = 32'(t1); end
            default: begin a_oh = 32'(oh2); a_idx = 32'(idx2); a_v = 32'(v2); a_t = 32'(t2); end
          endcase
          e_oh  = (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
          e_idx = (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0;
          chk($sformatf("model%0d_onehot", k), a_oh, e_oh);
          chk($sformatf("model%0d_idx", k), a_idx, e_idx);
          chk($sformatf("model%0d_valid", k), a_v, 32'(m_owner[k] >= 0));
          chk($sformatf("model%0d_timeout", k), a_t, 32'(m_to[k]));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          m_owner[k] = -1; m_ptr[k] = 0; m_age[k] = 0; m_to[k] = 1'b0;
        end else if (m_owner[k] < 0) begin
          m_to[k]    = 1'b0;
          m_owner[k] = pick(k, m_ptr[k]);
          m_age[k]   = 0;
        end else begin
          bit forced;
          forced = (mh[k] != 0) && (m_age[k] == mh[k] - 1);
          if (rel || forced) begin
            m_ptr[k]   = (m_owner[k] + 1) % nreq[k];
            m_to[k]    = forced && !rel;
            m_owner[k] = pick(k, m_ptr[k]);
            m_age[k]   = 0;
          end else begin
            m_age[k]++;
            m_to[k] = 1'b0;
          end
        end
      end
      if (rst) m_live = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq3[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset with all requests high
    rst = 1'b1; req = 4'b1111; rel = 1'b0;
    step(); step();
    chk("rst_onehot", 32'(oh0), 32'd0);
    chk("rst_idx", 32'(idx0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_timeout", 32'(t0), 32'd0);
    chk("rst_valid_mh8", 32'(v1), 32'd0);

    // First grant from idle, then frozen while req changes
    rst = 1'b0; req = 4'b1010;
    step();
    chk("first_onehot", 32'(oh0), 32'b0010);
    chk("first_idx", 32'(idx0), 32'd1);
    req = 4'b0101; step();
    chk("frozen_a", 32'(oh0), 32'b0010);
    req = 4'b0000; step();
    chk("frozen_b", 32'(oh0), 32'b0010);

    // Back-to-back rotation with release every cycle
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b1111; step();
    chk("rot_start", 32'(oh0), 32'b0001);
    rel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rot_%0d", i), 32'(oh0), 32'(seq3[i]));
    end

    // Release into no requests, release ignored in idle, pointer wrap
    step(); step();
    chk("busy_idx2", 32'(idx0), 32'd2);
    req = 4'b0000; step();
    chk("drop_valid", 32'(v0), 32'd0);
    chk("drop_onehot", 32'(oh0), 32'd0);
    step();
    chk("idle_rel", 32'(oh0), 32'd0);
    rel = 1'b0; req = 4'b0101; step();
    chk("wrap_idx", 32'(idx0), 32'd0);
    chk("wrap_onehot", 32'(oh0), 32'b0001);

    // Reset mid-grant clears the pointer
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0001; step();
    rel = 1'b1; req = 4'b1000; step();
    chk("pre_rst_idx3", 32'(idx0), 32'd3);
    rel = 1'b0; rst = 1'b1; step();
    chk("mid_rst_valid", 32'(v0), 32'd0);
    rst = 1'b0; req = 4'b1001; step();
    chk("post_rst_idx", 32'(idx0), 32'd0);

    // Hold timeout on the MAX_HOLD=8 instance: {valid,timeout,idx}
    rst = 1'b1; step();
    rst = 1'b0; req = 4'b0011; rel = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      logic [3:0] e;
      if (c == 25) rel = 1'b1;
      step();
      if (c <= 8)       e = 4'b1000;
      else if (c == 9)  e = 4'b1101;
      else if (c <= 16) e = 4'b1001;
      else if (c == 17) e = 4'b1100;
      else if (c <= 24) e = 4'b1000;
      else              e = 4'b1001;
      chk($sformatf("hold_c%0d", c), 32'({v1, t1, idx1}), 32'(e));
    end
    rel = 1'b0;

    // Mixed traffic checked by the model alone
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom);
      rel = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 80) == 0);
      step();
    end
    rst = 1'b0; rel = 1'b0; req = 4'b0000;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
